polar_fg_pe: RTL and testbench

POLAR_FG_PE -- requirements
Module: polar_fg_pe

---
 rtl/polar_fg_pe.sv | 222 ++++++++++++++++++++++
 tb/tb_polar_fg_pe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_fg_pe.sv
// Polar-decoder f/g processing element.
// Processes a frame of up to MAXLEN LLR pairs, LANES pairs per beat, through
// either the min-sum f function or the partial-sum g function, with one
// registered output stage and ready/valid handshakes on both sides.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode, len    frame request (accepted only in IDLE), operation, pair count
//   busy, done          status: busy outside IDLE, done one-cycle pulse at frame end
//   in_valid, in_ready  input beat handshake (in_ready is combinational)
//   a, b, u             LLR operand lanes and per-lane partial-sum bits
//   out_valid,out_ready output beat handshake
//   c, out_mask         result lanes and per-lane valid flags
module polar_fg_pe #(
    parameter int unsigned BITS   = 4,
    parameter int unsigned LANES  = 4,
    parameter int unsigned MAXLEN = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          mode,
    input  logic [$clog2(MAXLEN+1)-1:0]   len,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*BITS-1:0]         a,
    input  logic [LANES*BITS-1:0]         b,
    input  logic [LANES-1:0]              u,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*BITS-1:0]         c,
    output logic [LANES-1:0]              out_mask,
    output logic                          done
);

    localparam int unsigned LW       = $clog2(MAXLEN + 1);
    localparam int unsigned MAXBEATS = MAXLEN / LANES;
    localparam int unsigned BW       = $clog2(MAXBEATS + 1);
    localparam int unsigned W        = LANES * BITS;

    // Largest representable magnitude; results are kept inside +/-LIM.
    localparam logic signed [BITS:0] LIM  = (BITS+1)'((1 << (BITS - 1)) - 1);
    localparam logic signed [BITS:0] NLIM = -LIM;
    localparam logic [BITS-1:0]      MINV = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0]      MAXV = {1'b0, {(BITS-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [LW-1:0]   len_q, len_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic [BW-1:0]   in_cnt_q, in_cnt_d;
    logic [BW-1:0]   out_cnt_q, out_cnt_d;
    logic            ov_q, ov_d;
    logic [W-1:0]    c_q, c_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [LW-1:0]    len_clamp_c;
    logic [BW-1:0]    beats_calc_c;
    logic [W-1:0]     res_c;
    logic [LANES-1:0] bmask_c;
    logic             in_fire_c;
    logic             out_fire_c;

    // Saturating magnitude: the most negative code maps to the largest positive one.
    function automatic logic [BITS-1:0] abs_sat(input logic [BITS-1:0] x);
        if (x == MINV)
            return MAXV;
        else if (x[BITS-1])
            return -x;
        else
            return x;
    endfunction

    // Min-sum f: sign product times the smaller magnitude.
    function automatic logic [BITS-1:0] lane_f(input logic [BITS-1:0] x,
                                               input logic [BITS-1:0] y);
        logic [BITS-1:0] mx, my, mag;
        mx  = abs_sat(x);
        my  = abs_sat(y);
        mag = (mx < my) ? mx : my;
        return (x[BITS-1] ^ y[BITS-1]) ? -mag : mag;
    endfunction

    // Partial-sum g: y +/- x with one guard bit, clamped symmetrically.
    function automatic logic [BITS-1:0] lane_g(input logic [BITS-1:0] x,
                                               input logic [BITS-1:0] y,
                                               input logic            neg);
        logic signed [BITS:0] sx, sy, s;
        sx = $signed({x[BITS-1], x});
        sy = $signed({y[BITS-1], y});
        s  = neg ? (sy - sx) : (sy + sx);
        if (s > LIM)
            s = LIM;
        else if (s < NLIM)
            s = NLIM;
        return s[BITS-1:0];
    endfunction

    // Frame length clamp and beat count, used only when a start is accepted.
    always_comb begin
        len_clamp_c  = (len > LW'(MAXLEN)) ? LW'(MAXLEN) : len;
        beats_calc_c = BW'((32'(len_clamp_c) + LANES - 32'd1) / LANES);
    end

    // Handshakes; the input side can accept whenever the output slot frees this cycle.
    always_comb begin
        in_ready   = (state_q == S_RUN) && (in_cnt_q < beats_q) && (!ov_q || out_ready);
        in_fire_c  = in_valid && in_ready;
        out_fire_c = ov_q && out_ready;
    end

    // Per-lane datapath for the beat being accepted; lanes past the frame end are zero.
    always_comb begin
        res_c   = '0;
        bmask_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if ((32'(in_cnt_q) * LANES + 32'(i)) < 32'(len_q)) begin
                bmask_c[i] = 1'b1;
                res_c[i*BITS +: BITS] = mode_q ? lane_g(a[i*BITS +: BITS], b[i*BITS +: BITS], u[i])
                                               : lane_f(a[i*BITS +: BITS], b[i*BITS +: BITS]);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        beats_d   = beats_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        ov_d      = ov_q;
        c_d       = c_q;
        mask_d    = mask_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    len_d     = len_clamp_c;
                    beats_d   = beats_calc_c;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (len_clamp_c == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (out_fire_c) begin
                    out_cnt_d = out_cnt_q + BW'(1);
                    if (out_cnt_q == beats_q - BW'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output slot: load on accept, otherwise drain on handshake.
        if (in_fire_c) begin
            ov_d     = 1'b1;
            c_d      = res_c;
            mask_d   = bmask_c;
            in_cnt_d = in_cnt_q + BW'(1);
        end else if (out_fire_c) begin
            ov_d   = 1'b0;
            c_d    = '0;
            mask_d = '0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            len_q     <= '0;
            beats_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ov_q      <= 1'b0;
            c_q       <= '0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            beats_q   <= beats_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ov_q      <= ov_d;
            c_q       <= c_d;
            mask_q    <= mask_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = ov_q;
    assign c         = c_q;
    assign out_mask  = mask_q;

endmodule

// File: tb/tb_polar_fg_pe.sv
// Self-checking bench for polar_fg_pe: random frames against a frame-level
// reference model, plus fixed-vector, backpressure, len=0 and reset scenarios.
module tb_polar_fg_pe;

    localparam int unsigned BITS   = 4;
    localparam int unsigned LANES  = 4;
    localparam int unsigned MAXLEN = 16;
    localparam int unsigned LW     = $clog2(MAXLEN + 1);
    localparam int unsigned W      = LANES * BITS;
    localparam int          MAXM   = (1 << (BITS - 1)) - 1;
    localparam int          MINM   = -(1 << (BITS - 1));

    logic             clk, rst_n, start, mode;
    logic [LW-1:0]    len;
    logic             busy, in_valid, in_ready, out_valid, out_ready, done;
    logic [W-1:0]     a, b, c;
    logic [LANES-1:0] u, out_mask;

    polar_fg_pe #(.BITS(BITS), .LANES(LANES), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .u(u),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .out_mask(out_mask), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic int sx(input logic [BITS-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int abs_s(input int x);
        if (x == MINM) return MAXM;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int f_ref(input int x, input int y);
        int mag;
        mag = (abs_s(x) < abs_s(y)) ? abs_s(x) : abs_s(y);
        return (((x < 0) != (y < 0)) ? -mag : mag);
    endfunction

    function automatic int g_ref(input int x, input int y, input bit neg);
        int s;
        s = neg ? (y - x) : (y + x);
        if (s > MAXM) s = MAXM;
        if (s < -MAXM) s = -MAXM;
        return s;
    endfunction

    function automatic int lane_of(input logic [W-1:0] v, input int i);
        logic [BITS-1:0] t;
        t = v[i*BITS +: BITS];
        return sx(t);
    endfunction

    typedef struct {
        logic [W-1:0]     c;
        logic [LANES-1:0] m;
    } beat_t;

    // Frame-level model state.
    beat_t            q[$];
    int               m_phase = 0;   // 0 idle, 1 processing, 2 completion cycle
    bit               m_mode;
    int               m_len, m_in_idx, m_in_left, m_out_left;
    bit               prev_hold = 0;
    logic [W-1:0]     prev_c;
    logic [LANES-1:0] prev_m;
    logic [W-1:0]     last_c;
    logic [LANES-1:0] last_m;

    // Compare process: outputs are checked on every falling edge.
    initial begin
        bit    exp_ir;
        int    nph;
        beat_t nb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_busy", int'(busy), 0);
                check("rst_in_ready", int'(in_ready), 0);
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_c", int'(c), 0);
                check("rst_mask", int'(out_mask), 0);
                check("rst_done", int'(done), 0);
                q.delete();
                m_phase   = 0;
                prev_hold = 0;
                continue;
            end
            check("busy", int'(busy), int'(m_phase != 0));
            check("done", int'(done), int'(m_phase == 2));
            check("out_valid", int'(out_valid), int'(q.size() != 0));
            exp_ir = (m_phase == 1) && (m_in_left > 0) && ((q.size() == 0) || out_ready);
            check("in_ready", int'(in_ready), int'(exp_ir));
            if (prev_hold) begin
                check("hold_c", int'(c), int'(prev_c));
                check("hold_mask", int'(out_mask), int'(prev_m));
            end
            if (out_valid && q.size() > 0) begin
                check("c", int'(c), int'(q[0].c));
                check("out_mask", int'(out_mask), int'(q[0].m));
                for (int i = 0; i < int'(LANES); i++)
                    check("no_min_lane", int'(lane_of(c, i) == MINM), 0);
            end

            nph = m_phase;
            if (m_phase == 2) nph = 0;
            if (m_phase == 0 && start) begin
                m_mode     = mode;
                m_len      = (int'(len) > int'(MAXLEN)) ? int'(MAXLEN) : int'(len);
                m_in_idx   = 0;
                m_in_left  = (m_len + int'(LANES) - 1) / int'(LANES);
                m_out_left = m_in_left;
                nph        = (m_len == 0) ? 2 : 1;
            end
            if (out_valid && out_ready && q.size() > 0) begin
                last_c = c;
                last_m = out_mask;
                void'(q.pop_front());
                m_out_left--;
                if (m_out_left == 0) nph = 2;
            end
            if (in_valid && in_ready && m_in_left > 0) begin
                nb.c = '0;
                nb.m = '0;
                for (int i = 0; i < int'(LANES); i++) begin
                    if (m_in_idx * int'(LANES) + i < m_len) begin
                        int r;
                        r = m_mode ? g_ref(lane_of(a, i), lane_of(b, i), u[i])
                                   : f_ref(lane_of(a, i), lane_of(b, i));
                        nb.m[i] = 1'b1;
                        nb.c[i*BITS +: BITS] = BITS'(r);
                    end
                end
                q.push_back(nb);
                m_in_idx++;
                m_in_left--;
            end
            prev_hold = out_valid && !out_ready;
            prev_c    = c;
            prev_m    = out_mask;
            m_phase   = nph;
        end
    end

    // Output-side ready generator.
    int bp_cycles = 0;
    bit rdy_rand  = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_cycles > 0) begin
                out_ready = 1'b0;
                bp_cycles--;
            end else if (rdy_rand) begin
                out_ready = 1'($urandom_range(1));
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    logic [W-1:0]     fix_a, fix_b;
    logic [LANES-1:0] fix_u;

    task automatic wait_accept();
        bit got;
        got = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (!got) check("in_handshake_timeout", 0, 1);
    endtask

    task automatic run_frame(input bit md, input int ln, input bit use_fix,
                             input bit bp, input bit inj);
        int  ml, nbeats;
        bit  got;
        ml     = (ln > int'(MAXLEN)) ? int'(MAXLEN) : ln;
        nbeats = (ml + int'(LANES) - 1) / int'(LANES);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = md;
        len   = LW'(ln);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            if (use_fix) begin
                a = fix_a; b = fix_b; u = fix_u;
            end else begin
                a = W'($urandom); b = W'($urandom); u = LANES'($urandom);
            end
            if (inj && k == 1) begin
                start = 1'b1;
                mode  = ~md;
                len   = LW'(3);
            end
            if (bp && k == 1) bp_cycles = 5;
            wait_accept();
        end
        in_valid = 1'b0;
        got = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1;
                break;
            end
        end
        if (!got) check("frame_end_timeout", 0, 1);
    endtask

    initial begin
        int fa[4], fb[4];
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; len = '0;
        in_valid = 1'b0; a = '0; b = '0; u = '0;
        fix_a = '0; fix_b = '0; fix_u = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pin the reference arithmetic to hand-computed values.
        check("ref_f0", f_ref(-3, 5), -3);
        check("ref_f1", f_ref(-8, 7), -7);
        check("ref_f2", f_ref(0, -6), 0);
        check("ref_f3", f_ref(4, 4), 4);
        check("ref_g0", g_ref(5, 6, 0), 7);
        check("ref_g1", g_ref(5, 6, 1), 1);
        check("ref_g2", g_ref(7, -8, 0), -1);
        check("ref_g3", g_ref(7, -7, 1), -7);

        // Fixed f vectors.
        fa = '{-3, -8, 0, 4};
        fb = '{5, 7, -6, 4};
        for (int i = 0; i < 4; i++) begin
            fix_a[i*BITS +: BITS] = BITS'(fa[i]);
            fix_b[i*BITS +: BITS] = BITS'(fb[i]);
        end
        fix_u = 4'b1111;
        run_frame(1'b0, 4, 1'b1, 1'b0, 1'b0);
        check("lit_f0", lane_of(last_c, 0), -3);
        check("lit_f1", lane_of(last_c, 1), -7);
        check("lit_f2", lane_of(last_c, 2), 0);
        check("lit_f3", lane_of(last_c, 3), 4);

        // Fixed g vectors.
        fa = '{5, 5, 7, 7};
        fb = '{6, 6, -8, -7};
        for (int i = 0; i < 4; i++) begin
            fix_a[i*BITS +: BITS] = BITS'(fa[i]);
            fix_b[i*BITS +: BITS] = BITS'(fb[i]);
        end
        fix_u = 4'b1010;
        run_frame(1'b1, 4, 1'b1, 1'b0, 1'b0);
        check("lit_g0", lane_of(last_c, 0), 7);
        check("lit_g1", lane_of(last_c, 1), 1);
        check("lit_g2", lane_of(last_c, 2), -1);
        check("lit_g3", lane_of(last_c, 3), -7);

        // Partial last beat.
        run_frame(1'b0, 10, 1'b0, 1'b0, 1'b0);
        check("last_mask_len10", int'(last_m), 3);

        // Empty frame, start during a frame, backpressure, over-length clamp.
        run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 12, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, 16, 1'b0, 1'b1, 1'b0);
        run_frame(1'b1, 20, 1'b0, 1'b0, 1'b0);

        // Reset during the second beat of a full-length frame.
        @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b0; len = LW'(16);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
        wait_accept();
        a = W'($urandom); b = W'($urandom);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_out_valid", int'(out_valid), 0);
        check("async_c", int'(c), 0);
        check("async_mask", int'(out_mask), 0);
        check("async_done", int'(done), 0);
        check("async_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(1'b0, 4, 1'b0, 1'b0, 1'b0);

        // Randomized frames with random output stalls.
        rdy_rand = 1;
        for (int n = 0; n < 40; n++)
            run_frame(1'($urandom_range(1)), int'($urandom_range(20)), 1'b0, 1'b0,
                      ($urandom_range(3) == 0));
        rdy_rand = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
